i2s_sample_feeder: RTL and testbench

Stereo PCM buffer that sits directly upstream of the I2S transmitter. It accepts left/right sample pairs from the decoder through a valid/ready handshake and stores them in a frame FIFO. It presents one word at a time on `tx_data`, alternating left then right, and advances on each `tx_ready` pulse from the transmitter. On underrun it substitutes silence and keeps L/R alignment.

---
 rtl/i2s_sample_feeder_if.sv | 29 ++
 rtl/i2s_sample_feeder.sv | 161 ++++++++++++++++
 tb/tb_i2s_sample_feeder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_sample_feeder_if.sv
// Bundle of decoder-side and transmitter-side signals around the I2S sample feeder.
// The master modport is the environment (decoder + transmitter), the slave modport is the feeder.
interface i2s_sample_feeder_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_left;
    logic [WIDTH-1:0] in_right;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_chan;
    logic             underrun;
    logic             underrun_clr;
    logic [LW-1:0]    level;

    modport master (
        output in_valid, in_left, in_right, tx_ready, underrun_clr,
        input  in_ready, tx_data, tx_chan, underrun, level
    );

    modport slave (
        input  in_valid, in_left, in_right, tx_ready, underrun_clr,
        output in_ready, tx_data, tx_chan, underrun, level
    );
endinterface

// File: rtl/i2s_sample_feeder.sv
// Stereo frame FIFO feeding an I2S transmitter one word at a time (left, then right).
// On underrun a silence frame is inserted so the L/R phase is never lost.
module i2s_sample_feeder #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input logic              clk,
    input logic              rst,
    i2s_sample_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [WIDTH-1:0] SILENCE = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    // Frame storage: {left, right} per entry
    logic [2*WIDTH-1:0] mem_r [DEPTH];

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] tx_data_r;
    logic [WIDTH-1:0] tx_data_s;
    logic             tx_chan_r;
    logic             tx_chan_s;
    logic [WIDTH-1:0] cur_right_r;
    logic [WIDTH-1:0] cur_right_s;
    logic             underrun_r;
    logic             underrun_s;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             set_underrun_s;
    logic [WIDTH-1:0] head_left_s;
    logic [WIDTH-1:0] head_right_s;

    // Pointer-derived status: full when only the wrap bit differs
    always_comb begin
        full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        empty_s      = (wr_ptr_r == rd_ptr_r);
        push_s       = bus.in_valid && !full_s;
        head_left_s  = mem_r[rd_ptr_r[AW-1:0]][2*WIDTH-1:WIDTH];
        head_right_s = mem_r[rd_ptr_r[AW-1:0]][WIDTH-1:0];
    end

    assign bus.in_ready = !full_s;
    assign bus.level    = wr_ptr_r - rd_ptr_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.tx_chan  = tx_chan_r;
    assign bus.underrun = underrun_r;

    // Frame write into storage; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {bus.in_left, bus.in_right};
        end
    end

    // Next-state and output decode for the PRIME/LEFT/RIGHT sequencer
    always_comb begin
        state_s        = state_r;
        tx_data_s      = tx_data_r;
        tx_chan_s      = tx_chan_r;
        cur_right_s    = cur_right_r;
        pop_s          = 1'b0;
        set_underrun_s = 1'b0;
        case (state_r)
            PRIME: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    tx_data_s   = head_left_s;
                    cur_right_s = head_right_s;
                    tx_chan_s   = 1'b0;
                    state_s     = LEFT;
                end else begin
                    tx_data_s = SILENCE;
                    tx_chan_s = 1'b0;
                end
            end
            LEFT: begin
                if (bus.tx_ready) begin
                    tx_data_s = cur_right_r;
                    tx_chan_s = 1'b1;
                    state_s   = RIGHT;
                end else begin
                    state_s = LEFT;
                end
            end
            RIGHT: begin
                if (bus.tx_ready && !empty_s) begin
                    pop_s       = 1'b1;
                    tx_data_s   = head_left_s;
                    cur_right_s = head_right_s;
                    tx_chan_s   = 1'b0;
                    state_s     = LEFT;
                end else if (bus.tx_ready) begin
                    // Silence frame keeps the channel phase; never fall back to PRIME
                    tx_data_s      = SILENCE;
                    cur_right_s    = SILENCE;
                    tx_chan_s      = 1'b0;
                    set_underrun_s = 1'b1;
                    state_s        = LEFT;
                end else begin
                    state_s = RIGHT;
                end
            end
            default: begin
                state_s     = PRIME;
                tx_data_s   = SILENCE;
                tx_chan_s   = 1'b0;
                cur_right_s = SILENCE;
            end
        endcase
    end

    // Sticky underrun: a new set wins over a simultaneous clear
    always_comb begin
        if (set_underrun_s) begin
            underrun_s = 1'b1;
        end else if (bus.underrun_clr) begin
            underrun_s = 1'b0;
        end else begin
            underrun_s = underrun_r;
        end
    end

    // State, output and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= PRIME;
            tx_data_r   <= SILENCE;
            tx_chan_r   <= 1'b0;
            cur_right_r <= SILENCE;
            underrun_r  <= 1'b0;
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
        end else begin
            state_r     <= state_s;
            tx_data_r   <= tx_data_s;
            tx_chan_r   <= tx_chan_s;
            cur_right_r <= cur_right_s;
            underrun_r  <= underrun_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end
endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Directed bench for i2s_sample_feeder: reset, ordering, underrun, backpressure, wrap, reset mid-stream.
module tb_i2s_sample_feeder;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    i2s_sample_feeder_if #(.WIDTH(16), .DEPTH(8)) bus ();

    i2s_sample_feeder #(.WIDTH(16), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
        bus.in_valid = 1'b1;
        bus.in_left  = l;
        bus.in_right = r;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_tx();
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    logic [15:0] exp_seq [8];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_left      = 16'h0000;
        bus.in_right     = 16'h0000;
        bus.tx_ready     = 1'b0;
        bus.underrun_clr = 1'b0;
        idle(2);
        rst = 1'b0;
        tick();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_level", {28'd0, bus.level}, 32'd0);

        // 1. First-word latency, then asynchronous reset mid-cycle
        push_frame(16'h1234, 16'h5678);
        check("prime_not_yet", {16'd0, bus.tx_data}, 32'h0000);
        check("prime_level1", {28'd0, bus.level}, 32'd1);
        tick();
        check("first_word", {16'd0, bus.tx_data}, 32'h1234);
        check("first_level0", {28'd0, bus.level}, 32'd0);
        #3 rst = 1'b1;
        #1;
        check("async_tx_data", {16'd0, bus.tx_data}, 32'h0000);
        check("async_tx_chan", {31'd0, bus.tx_chan}, 32'd0);
        check("async_underrun", {31'd0, bus.underrun}, 32'd0);
        check("async_level", {28'd0, bus.level}, 32'd0);
        check("async_in_ready", {31'd0, bus.in_ready}, 32'd1);
        #2 rst = 1'b0;
        tick();

        // 2. Frame ordering and underrun on the first silence word
        push_frame(16'h1111, 16'h2222);
        bus.in_valid = 1'b1; bus.in_left = 16'h3333; bus.in_right = 16'h4444;
        tick();
        check("push_pop_same_level", {28'd0, bus.level}, 32'd1);
        bus.in_left = 16'h5555; bus.in_right = 16'h6666;
        tick();
        bus.in_valid = 1'b0;
        check("ord_level2", {28'd0, bus.level}, 32'd2);
        check("ord_word0", {16'd0, bus.tx_data}, 32'h1111);
        check("ord_chan0", {31'd0, bus.tx_chan}, 32'd0);
        exp_seq[0] = 16'h2222; exp_seq[1] = 16'h3333; exp_seq[2] = 16'h4444;
        exp_seq[3] = 16'h5555; exp_seq[4] = 16'h6666; exp_seq[5] = 16'h0000;
        exp_seq[6] = 16'h0000; exp_seq[7] = 16'h0000;
        for (int k = 0; k < 7; k++) begin
            idle(31);
            check("ord_underrun_before", {31'd0, bus.underrun}, (k == 6) ? 32'd1 : 32'd0);
            pulse_tx();
            check("ord_word", {16'd0, bus.tx_data}, {16'd0, exp_seq[k]});
            check("ord_chan", {31'd0, bus.tx_chan}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("ord_underrun", {31'd0, bus.underrun}, (k >= 5) ? 32'd1 : 32'd0);
        end

        // 3. Underrun recovery, clear, and set-beats-clear
        push_frame(16'hAAAA, 16'hBBBB);
        check("rec_hold_silence", {16'd0, bus.tx_data}, 32'h0000);
        tick();
        pulse_tx();
        check("rec_left", {16'd0, bus.tx_data}, 32'hAAAA);
        check("rec_chan", {31'd0, bus.tx_chan}, 32'd0);
        check("rec_level", {28'd0, bus.level}, 32'd0);
        bus.underrun_clr = 1'b1;
        tick();
        bus.underrun_clr = 1'b0;
        check("clr_underrun", {31'd0, bus.underrun}, 32'd0);
        idle(2);
        pulse_tx();
        check("rec_right", {16'd0, bus.tx_data}, 32'hBBBB);
        idle(2);
        bus.tx_ready = 1'b1; bus.underrun_clr = 1'b1;
        tick();
        bus.tx_ready = 1'b0; bus.underrun_clr = 1'b0;
        check("set_beats_clr", {31'd0, bus.underrun}, 32'd1);
        check("set_silence", {16'd0, bus.tx_data}, 32'h0000);
        do_reset();

        // 4. Backpressure at full
        for (int k = 0; k < 9; k++) begin
            bus.in_valid = 1'b1;
            bus.in_left  = 16'h0100 + 16'(k);
            bus.in_right = 16'h0200 + 16'(k);
            tick();
        end
        bus.in_left = 16'h0109; bus.in_right = 16'h0209;
        check("bp_level_full", {28'd0, bus.level}, 32'd8);
        check("bp_in_ready0", {31'd0, bus.in_ready}, 32'd0);
        check("bp_word", {16'd0, bus.tx_data}, 32'h0100);
        tick();
        check("bp_held_level", {28'd0, bus.level}, 32'd8);
        pulse_tx();
        check("bp_right", {16'd0, bus.tx_data}, 32'h0200);
        check("bp_no_pop_left", {28'd0, bus.level}, 32'd8);
        idle(2);
        pulse_tx();
        check("bp_pop_word", {16'd0, bus.tx_data}, 32'h0101);
        check("bp_refused_level", {28'd0, bus.level}, 32'd7);
        check("bp_in_ready1", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_late_push", {28'd0, bus.level}, 32'd8);
        do_reset();

        // 5. Pointer wrap with 1:1 streaming
        push_frame(16'h1000, 16'h8000);
        tick();
        check("wrap_first", {16'd0, bus.tx_data}, 32'h1000);
        for (int i = 1; i < 100; i++) begin
            bus.in_valid = 1'b1;
            bus.in_left  = 16'h1000 + 16'(i);
            bus.in_right = 16'h8000 + 16'(i);
            bus.tx_ready = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            bus.tx_ready = 1'b0;
            check("wrap_right", {16'd0, bus.tx_data}, {16'd0, 16'h8000 + 16'(i - 1)});
            tick();
            pulse_tx();
            check("wrap_left", {16'd0, bus.tx_data}, {16'd0, 16'h1000 + 16'(i)});
            tick();
        end
        pulse_tx();
        check("wrap_last", {16'd0, bus.tx_data}, 32'h8063);
        check("wrap_no_underrun", {31'd0, bus.underrun}, 32'd0);
        do_reset();

        // 6. Reset in RIGHT with five frames stored
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            bus.in_left  = 16'h0A00 + 16'(k);
            bus.in_right = 16'h0B00 + 16'(k);
            tick();
        end
        bus.in_valid = 1'b0;
        pulse_tx();
        check("mid_level5", {28'd0, bus.level}, 32'd5);
        check("mid_chan_right", {31'd0, bus.tx_chan}, 32'd1);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_level", {28'd0, bus.level}, 32'd0);
        check("mid_rst_data", {16'd0, bus.tx_data}, 32'h0000);
        #2 rst = 1'b0;
        tick();
        push_frame(16'hCAFE, 16'hBEEF);
        tick();
        check("mid_after_left", {16'd0, bus.tx_data}, 32'hCAFE);
        check("mid_after_chan", {31'd0, bus.tx_chan}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
